// File: rtl/instruction_fetch_axi_pkg.sv
// Shared definitions for the instruction fetch AXI read master.
//   fetch_state_e : FSM encoding (IDLE, AR, DATA, DONE)
//   BURST_INCR    : AXI ARBURST encoding for incrementing bursts
//   RESP_OKAY     : AXI RRESP encoding for a good beat
//   axi_size()    : ARSIZE value for a given data bus width in bits
package instruction_fetch_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // ARSIZE is log2 of the bytes per beat.
  function automatic logic [2:0] axi_size(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/instruction_fetch_axi_if.sv
// AXI4 read-only bus (AR + R channels) between the fetch master and DRAM.
//   master : drives AR fields/arvalid and rready
//   slave  : drives arready and the R channel
interface instruction_fetch_axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/instruction_fetch_axi.sv
// AXI4 read master that fills the instruction memory double buffer.
// Each imem_wr_start pulse fetches the next block of the program (up to
// cfg_block_beats beats) as one or more INCR bursts of at most MAX_BURST
// beats, streams every beat on imem_wr_data/imem_wr_data_valid, and closes
// the block with a one-cycle imem_wr_done. Once the program is exhausted,
// blocks are empty but still complete with a done pulse.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   cfg_load            : latch cfg_base_addr/cfg_total_beats, clear rd_err
//   cfg_block_beats     : beats per block (sampled at each start)
//   imem_wr_start       : request next block (only honoured when idle)
//   imem_wr_done        : block complete pulse
//   imem_wr_data(_valid): registered beat stream, one cycle after R handshake
//   busy                : FSM not idle
//   rd_err              : sticky bad rresp / rlast mismatch since cfg_load
//   m_axi               : AXI4 AR/R master
module instruction_fetch_axi
  import instruction_fetch_axi_pkg::*;
#(
  parameter int NUM_INST_IN     = 2,
  parameter int INST_DATA_WIDTH = 32,
  parameter int AXI_DATA_WIDTH  = NUM_INST_IN * INST_DATA_WIDTH,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int BLOCK_BEATS_W   = 10,
  parameter int MAX_BURST       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_load,
  input  logic [AXI_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [BLOCK_BEATS_W-1:0]  cfg_total_beats,
  input  logic [BLOCK_BEATS_W-1:0]  cfg_block_beats,
  input  logic                      imem_wr_start,
  output logic                      imem_wr_done,
  output logic                      imem_wr_data_valid,
  output logic [AXI_DATA_WIDTH-1:0] imem_wr_data,
  output logic                      busy,
  output logic                      rd_err,
  instruction_fetch_axi_if.master   m_axi
);

  localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;
  localparam int BURST_W    = $clog2(MAX_BURST) + 1;
  localparam logic [BLOCK_BEATS_W-1:0] MAX_BURST_B = BLOCK_BEATS_W'(MAX_BURST);

  fetch_state_e              state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [BLOCK_BEATS_W-1:0]  prog_left_q, prog_left_d;
  logic [BLOCK_BEATS_W-1:0]  blk_left_q, blk_left_d;
  logic [BURST_W-1:0]        burst_left_q, burst_left_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]                arlen_q, arlen_d;
  logic [2:0]                arsize_q, arsize_d;
  logic [1:0]                arburst_q, arburst_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic                      wr_valid_q, wr_valid_d;
  logic [AXI_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                      wr_done_q, wr_done_d;
  logic                      rd_err_q, rd_err_d;

  // Scratch values for the block and burst sizing.
  logic [BLOCK_BEATS_W-1:0]  prog_avail;
  logic [BLOCK_BEATS_W-1:0]  blk_start;
  logic [BLOCK_BEATS_W-1:0]  burst_beats;
  logic                      last_of_burst;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    prog_left_d  = prog_left_q;
    blk_left_d   = blk_left_q;
    burst_left_d = burst_left_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arburst_d    = arburst_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    wr_valid_d   = 1'b0;
    wr_data_d    = wr_data_q;
    wr_done_d    = 1'b0;
    rd_err_d     = rd_err_q;

    // A start in the same cycle as a load sizes its block from the newly
    // loaded program length, so neither request is lost.
    prog_avail    = cfg_load ? cfg_total_beats : prog_left_q;
    blk_start     = (cfg_block_beats < prog_avail) ? cfg_block_beats : prog_avail;
    burst_beats   = (blk_left_q > MAX_BURST_B) ? MAX_BURST_B : blk_left_q;
    last_of_burst = (burst_left_q == BURST_W'(1));

    case (state_q)
      ST_IDLE: begin
        if (cfg_load) begin
          ptr_d       = cfg_base_addr;
          prog_left_d = cfg_total_beats;
          rd_err_d    = 1'b0;
        end
        if (imem_wr_start) begin
          blk_left_d = blk_start;
          state_d    = (blk_start == '0) ? ST_DONE : ST_AR;
        end
      end

      ST_AR: begin
        // First AR cycle loads the request; it then holds until accepted.
        if (!arvalid_q) begin
          arvalid_d = 1'b1;
          araddr_d  = ptr_q;
          arlen_d   = 8'(burst_beats - 1'b1);
          arsize_d  = axi_size(AXI_DATA_WIDTH);
          arburst_d = BURST_INCR;
        end else if (m_axi.arready) begin
          arvalid_d    = 1'b0;
          ptr_d        = ptr_q + AXI_ADDR_WIDTH'((32'(arlen_q) + 32'd1) * 32'(BEAT_BYTES));
          burst_left_d = BURST_W'({1'b0, arlen_q} + 9'd1);
          rready_d     = 1'b1;
          state_d      = ST_DATA;
        end
      end

      ST_DATA: begin
        if (rready_q && m_axi.rvalid) begin
          wr_valid_d   = 1'b1;
          wr_data_d    = m_axi.rdata;
          burst_left_d = burst_left_q - 1'b1;
          blk_left_d   = blk_left_q - 1'b1;
          prog_left_d  = prog_left_q - 1'b1;
          // Beat counting is ours; rlast is only cross-checked.
          if (m_axi.rresp != RESP_OKAY || m_axi.rlast != last_of_burst)
            rd_err_d = 1'b1;
          if (last_of_burst) begin
            rready_d = 1'b0;
            state_d  = (blk_left_q == BLOCK_BEATS_W'(1)) ? ST_DONE : ST_AR;
          end
        end
      end

      ST_DONE: begin
        // Registered, so done lands one cycle after the last data beat.
        wr_done_d = 1'b1;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      prog_left_q  <= '0;
      blk_left_q   <= '0;
      burst_left_q <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_data_q    <= '0;
      wr_done_q    <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      prog_left_q  <= prog_left_d;
      blk_left_q   <= blk_left_d;
      burst_left_q <= burst_left_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      wr_valid_q   <= wr_valid_d;
      wr_data_q    <= wr_data_d;
      wr_done_q    <= wr_done_d;
      rd_err_q     <= rd_err_d;
    end
  end

  assign m_axi.araddr       = araddr_q;
  assign m_axi.arlen        = arlen_q;
  assign m_axi.arsize       = arsize_q;
  assign m_axi.arburst      = arburst_q;
  assign m_axi.arvalid      = arvalid_q;
  assign m_axi.rready       = rready_q;
  assign imem_wr_data_valid = wr_valid_q;
  assign imem_wr_data       = wr_data_q;
  assign imem_wr_done       = wr_done_q;
  assign rd_err             = rd_err_q;
  assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_instruction_fetch_axi.sv
// Scoreboard bench for instruction_fetch_axi with a behavioural DRAM slave.
module tb_instruction_fetch_axi;
  import instruction_fetch_axi_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int BBW = 10;
  localparam int MB  = 4;

  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { int beats; int start_cyc; } blk_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           cfg_load = 1'b0;
  logic           imem_wr_start = 1'b0;
  logic [AW-1:0]  cfg_base_addr = '0;
  logic [BBW-1:0] cfg_total_beats = '0;
  logic [BBW-1:0] cfg_block_beats = '0;
  logic           imem_wr_done, imem_wr_data_valid, busy, rd_err;
  logic [DW-1:0]  imem_wr_data;

  instruction_fetch_axi_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

  instruction_fetch_axi #(
    .NUM_INST_IN(2), .INST_DATA_WIDTH(32), .AXI_ADDR_WIDTH(AW),
    .BLOCK_BEATS_W(BBW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_base_addr(cfg_base_addr),
    .cfg_total_beats(cfg_total_beats), .cfg_block_beats(cfg_block_beats),
    .imem_wr_start(imem_wr_start), .imem_wr_done(imem_wr_done),
    .imem_wr_data_valid(imem_wr_data_valid), .imem_wr_data(imem_wr_data),
    .busy(busy), .rd_err(rd_err), .m_axi(axi.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, blk_beats = 0, last_valid_cyc = 0;
  // slave knobs / state visible to the stimulus
  int ar_delay = 0, rv_mode = 0, err_beat = -1, r_beats = 0;
  // reference model of the program pointer
  logic [31:0] m_ptr = '0;
  int m_left = 0, m_blk = 1;
  logic exp_err = 1'b0;

  logic [63:0] exp_q[$];
  ar_t         exp_ar[$];
  blk_t        exp_blk[$];

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {~a, a ^ 32'hA5A5_5A5A};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // DRAM slave: acts just after each negedge so its outputs are settled
  // before the next posedge; a handshake decided here completes on that edge.
  initial begin
    int burst_rem, ar_wait, pat;
    logic [31:0] raddr;
    burst_rem = 0; ar_wait = 0; pat = 0; raddr = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;
    axi.rresp = RESP_OKAY; axi.rlast = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (!reset) begin
        burst_rem = 0; ar_wait = 0; pat = 0;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = RESP_OKAY;
      end else if (burst_rem > 0) begin
        axi.arready = 1'b0;
        case (rv_mode)
          0:       axi.rvalid = 1'b1;
          1:       axi.rvalid = (pat % 4 == 0) || (pat % 4 == 3);
          default: axi.rvalid = ($urandom_range(0, 2) != 0);
        endcase
        pat++;
        axi.rdata = mem_word(raddr);
        axi.rlast = (burst_rem == 1);
        axi.rresp = (r_beats == err_beat) ? 2'b10 : RESP_OKAY;
        if (axi.rvalid && axi.rready) begin
          raddr += 32'd8; burst_rem--; r_beats++;
        end
      end else begin
        axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = RESP_OKAY;
        if (axi.arvalid) begin
          axi.arready = (ar_wait >= ar_delay);
          if (axi.arready) begin
            raddr = axi.araddr; burst_rem = int'(axi.arlen) + 1; ar_wait = 0; pat = 0;
          end else ar_wait++;
        end else axi.arready = 1'b0;
      end
    end
  end

  // Monitor: compares everything the DUT presents against the queues.
  initial begin
    logic prev_rfire, prev_stall;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;
    ar_t a;
    blk_t b;
    prev_rfire = 1'b0; prev_stall = 1'b0; prev_addr = '0; prev_len = '0;
    forever begin
      @(negedge clk); #2;
      cyc++;
      if (imem_wr_data_valid) begin
        blk_beats++;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) chk("beat_unexpected", 64'd1, 64'd0);
        else chk("beat_data", imem_wr_data, exp_q.pop_front());
      end
      if (imem_wr_data_valid || prev_rfire)
        chk("valid_follows_rfire", {63'd0, imem_wr_data_valid}, {63'd0, prev_rfire});
      prev_rfire = axi.rvalid && axi.rready && reset;

      if (prev_stall) begin
        chk("ar_hold_valid", {63'd0, axi.arvalid}, 64'd1);
        chk("ar_hold_addr", {32'd0, axi.araddr}, {32'd0, prev_addr});
        chk("ar_hold_len", {56'd0, axi.arlen}, {56'd0, prev_len});
      end
      prev_stall = axi.arvalid && !axi.arready && reset;
      prev_addr  = axi.araddr;
      prev_len   = axi.arlen;
      if (axi.arvalid && axi.arready && reset) begin
        if (exp_ar.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
        else begin
          a = exp_ar.pop_front();
          chk("araddr", {32'd0, axi.araddr}, {32'd0, a.addr});
          chk("arlen", {56'd0, axi.arlen}, {56'd0, a.len});
          chk("arsize", {61'd0, axi.arsize}, 64'd3);
          chk("arburst", {62'd0, axi.arburst}, 64'd1);
        end
      end

      if (imem_wr_done) begin
        done_cnt++;
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        if (exp_blk.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
        else begin
          b = exp_blk.pop_front();
          chk("block_beats", 64'(blk_beats), 64'(b.beats));
          if (b.beats > 0) chk("done_after_last_valid", 64'(cyc - last_valid_cyc), 64'd1);
          else             chk("done_after_start", 64'(cyc - b.start_cyc), 64'd2);
        end
        blk_beats = 0;
      end
    end
  end

  task automatic cfg(input logic [31:0] base, input int total, input int blk);
    @(negedge clk);
    cfg_base_addr = base; cfg_total_beats = BBW'(total); cfg_block_beats = BBW'(blk);
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    m_ptr = base; m_left = total; m_blk = blk; exp_err = 1'b0;
    chk("rd_err_after_load", {63'd0, rd_err}, 64'd0);
  endtask

  // Reference model: the block is min(block, remaining) beats from the
  // program pointer, split into bursts of at most MB beats.
  task automatic issue_start();
    int blk, rem, n;
    logic [31:0] a;
    @(negedge clk);
    blk = (m_blk < m_left) ? m_blk : m_left;
    exp_blk.push_back('{blk, cyc + 1});
    for (int i = 0; i < blk; i++) exp_q.push_back(mem_word(m_ptr + 32'(i * 8)));
    a = m_ptr; rem = blk;
    while (rem > 0) begin
      n = (rem > MB) ? MB : rem;
      exp_ar.push_back('{a, 8'(n - 1)});
      a += 32'(n * 8); rem -= n;
    end
    m_ptr += 32'(blk * 8); m_left -= blk;
    imem_wr_start = 1'b1;
    @(negedge clk);
    imem_wr_start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic start_blk();
    int target;
    target = done_cnt + 1;
    issue_start();
    for (int t = 0; t < 3000 && done_cnt < target; t++) @(negedge clk);
    if (done_cnt < target) chk("done_timeout", 64'(done_cnt), 64'(target));
    if (err_beat >= 0 && r_beats > err_beat) exp_err = 1'b1;
    chk("rd_err", {63'd0, rd_err}, {63'd0, exp_err});
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_arvalid"}, {63'd0, axi.arvalid}, 64'd0);
    chk({tag, "_araddr"}, {32'd0, axi.araddr}, 64'd0);
    chk({tag, "_arlen_size_burst"}, {51'd0, axi.arlen, axi.arsize, axi.arburst}, 64'd0);
    chk({tag, "_rready"}, {63'd0, axi.rready}, 64'd0);
    chk({tag, "_wr_valid_done"}, {62'd0, imem_wr_data_valid, imem_wr_done}, 64'd0);
    chk({tag, "_wr_data"}, imem_wr_data, 64'd0);
    chk({tag, "_busy_err"}, {62'd0, busy, rd_err}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;

    // basic program: two full bursts
    cfg(32'h1000, 8, 8);
    start_blk();

    // 8, 8, 4 and then an empty block
    cfg(32'h1400, 20, 8);
    repeat (4) start_blk();

    // AR held off for five cycles
    ar_delay = 5;
    cfg(32'h1800, 4, 4);
    start_blk();
    ar_delay = 0;

    // rvalid gaps 1,0,0,1
    rv_mode = 1;
    cfg(32'h1C00, 8, 8);
    start_blk();
    rv_mode = 0;

    // SLVERR on the third beat: sticky until the next load
    r_beats = 0; err_beat = 2;
    cfg(32'h1000, 8, 8);
    start_blk();
    repeat (3) @(negedge clk);
    chk("rd_err_sticky", {63'd0, rd_err}, 64'd1);
    err_beat = -1;
    cfg(32'h1000, 8, 8);

    // reset in the middle of a burst
    r_beats = 0;
    cfg(32'h3000, 8, 8);
    issue_start();
    t = 0;
    while (r_beats < 2 && t < 200) begin @(negedge clk); t++; end
    if (r_beats < 2) chk("reset_test_timeout", 64'(r_beats), 64'd2);
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("midburst_reset");
    exp_q.delete(); exp_ar.delete(); exp_blk.delete();
    blk_beats = 0; m_ptr = '0; m_left = 0;
    reset = 1'b1;
    cfg(32'h2000, 8, 8);
    start_blk();

    // randomized programs
    for (int it = 0; it < 8; it++) begin
      int total, blk, starts;
      ar_delay = $urandom_range(0, 3);
      rv_mode  = $urandom_range(0, 2);
      total    = $urandom_range(0, 30);
      blk      = $urandom_range(1, 12);
      cfg(32'($urandom_range(0, 1023)) * 32'd32, total, blk);
      starts = 0;
      while (m_left > 0 && starts < 40) begin start_blk(); starts++; end
      start_blk();
    end

    repeat (5) @(negedge clk);
    chk("leftover_beats", 64'(exp_q.size()), 64'd0);
    chk("leftover_ars", 64'(exp_ar.size()), 64'd0);
    chk("leftover_blocks", 64'(exp_blk.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
